// File: rtl/huff_pkg.sv
// Shared definitions for the Huffman bit packer: symbol encodings,
// packer FSM states and code/length table field widths.
package huff_pkg;

    localparam logic [1:0] SYM_A = 2'd0;
    localparam logic [1:0] SYM_B = 2'd1;
    localparam logic [1:0] SYM_C = 2'd2;
    localparam logic [1:0] SYM_D = 2'd3;

    localparam int CODE_FLD_W   = 4;
    localparam int LEN_FLD_W    = 2;
    localparam int MAX_CODE_LEN = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FLUSH  = 2'd2,
        DONE_S = 2'd3
    } state_t;

endpackage

// File: rtl/huff_code_lookup.sv
// Combinational code/length lookup for one symbol from the latched
// 4-entry tables. The returned code is masked to its length so that
// stray bits above LEN in the table field never reach the accumulator.
module huff_code_lookup
    import huff_pkg::*;
(
    input  logic [4*CODE_FLD_W-1:0] code_tbl,
    input  logic [4*LEN_FLD_W-1:0]  len_tbl,
    input  logic [1:0]              sym,
    output logic [CODE_FLD_W-1:0]   code,
    output logic [LEN_FLD_W-1:0]    len
);

    logic [CODE_FLD_W-1:0] mask;

    // Select the symbol's fields and keep only the low LEN code bits.
    always_comb begin
        len  = len_tbl[sym*LEN_FLD_W +: LEN_FLD_W];
        mask = CODE_FLD_W'((32'd1 << len) - 32'd1);
        code = code_tbl[sym*CODE_FLD_W +: CODE_FLD_W] & mask;
    end

endmodule

// File: rtl/huffman_bit_packer.sv
// Huffman bit packer: latches code/length tables, packs 2-bit symbols
// into MSB-first OUT_W-bit words, zero-pads and flags the final word.
// Optional build macro HUFF_BIT_COUNT_EN adds the TOTAL_BITS counter.
//
// The accumulator is kept left-aligned: the valid bits always occupy the
// top bit_cnt positions, so the output word is simply the top OUT_W bits
// and a residual flush is already zero-padded below.
module huffman_bit_packer
    import huff_pkg::*;
#(
    parameter int OUT_W = 8,
    parameter int ACC_W = OUT_W + 3
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    TABLE_LOAD,
    input  logic [4*CODE_FLD_W-1:0] CODE_TABLE,
    input  logic [4*LEN_FLD_W-1:0]  LEN_TABLE,
    input  logic [1:0]              SYM,
    input  logic                    SYM_VALID,
    input  logic                    SYM_LAST,
    output logic                    SYM_READY,
    output logic [OUT_W-1:0]        OUT_DATA,
    output logic                    OUT_VALID,
    output logic                    OUT_LAST,
    output logic [3:0]              OUT_PAD,
    input  logic                    OUT_READY,
    output logic                    DONE,
    output logic                    ERR
`ifdef HUFF_BIT_COUNT_EN
    ,
    output logic [31:0]             TOTAL_BITS
`endif
);

    localparam int CNT_W = $clog2(ACC_W + 1);

    state_t                  state_q, state_d;
    logic [ACC_W-1:0]        acc_q, acc_d;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [4*CODE_FLD_W-1:0] code_tbl_q, code_tbl_d;
    logic [4*LEN_FLD_W-1:0]  len_tbl_q, len_tbl_d;
    logic                    err_q, err_d;

    logic [CODE_FLD_W-1:0]   sym_code;
    logic [LEN_FLD_W-1:0]    sym_len;
    logic [ACC_W-1:0]        code_ext;
    logic [CNT_W-1:0]        ins_sh;
    logic                    full;
    logic                    accept;
    logic                    sym_ready;
    logic                    out_valid;
    logic                    out_last;
    logic [3:0]              out_pad;
    logic                    done;

    huff_code_lookup u_lookup (
        .code_tbl (code_tbl_q),
        .len_tbl  (len_tbl_q),
        .sym      (SYM),
        .code     (sym_code),
        .len      (sym_len)
    );

    // Next-state, accumulator update and handshake outputs.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        bit_cnt_d  = bit_cnt_q;
        code_tbl_d = code_tbl_q;
        len_tbl_d  = len_tbl_q;
        err_d      = err_q;
        sym_ready  = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        out_pad    = 4'd0;
        done       = 1'b0;
        accept     = 1'b0;

        full     = (bit_cnt_q >= CNT_W'(OUT_W));
        code_ext = ACC_W'(sym_code);
        // New code lands directly below the bits already held.
        ins_sh   = CNT_W'(ACC_W) - bit_cnt_q - CNT_W'(sym_len);

        case (state_q)
            IDLE: begin
                if (TABLE_LOAD) begin
                    code_tbl_d = CODE_TABLE;
                    len_tbl_d  = LEN_TABLE;
                    err_d      = 1'b0;
                    acc_d      = '0;
                    bit_cnt_d  = '0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                sym_ready = !full;
                out_valid = full;
                accept    = SYM_VALID && sym_ready;
                if (accept) begin
                    acc_d     = acc_q | (code_ext << ins_sh);
                    bit_cnt_d = bit_cnt_q + CNT_W'(sym_len);
                    if (sym_len == '0) begin
                        err_d = 1'b1;
                    end
                    if (SYM_LAST) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (full) begin
                    out_valid = 1'b1;
                    out_last  = (bit_cnt_q == CNT_W'(OUT_W));
                end else if (bit_cnt_q != '0) begin
                    out_valid = 1'b1;
                    out_last  = 1'b1;
                    out_pad   = 4'(CNT_W'(OUT_W) - bit_cnt_q);
                end else begin
                    // Session carried no code bits at all.
                    state_d = DONE_S;
                end
            end
            DONE_S: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Accept and transfer are mutually exclusive, so this never
        // overrides an append made above.
        if (out_valid && OUT_READY) begin
            acc_d = acc_q << OUT_W;
            if (out_last) begin
                bit_cnt_d = '0;
                state_d   = DONE_S;
            end else begin
                bit_cnt_d = bit_cnt_q - CNT_W'(OUT_W);
            end
        end
    end

    // State, accumulator and latched tables; reset aborts any session.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            bit_cnt_q  <= '0;
            code_tbl_q <= '0;
            len_tbl_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            bit_cnt_q  <= bit_cnt_d;
            code_tbl_q <= code_tbl_d;
            len_tbl_q  <= len_tbl_d;
            err_q      <= err_d;
        end
    end

    assign SYM_READY = sym_ready;
    assign OUT_DATA  = acc_q[ACC_W-1 -: OUT_W];
    assign OUT_VALID = out_valid;
    assign OUT_LAST  = out_last;
    assign OUT_PAD   = out_pad;
    assign DONE      = done;
    assign ERR       = err_q;

`ifdef HUFF_BIT_COUNT_EN
    logic [31:0] total_q, total_d;
    logic [32:0] total_sum;

    // Saturating count of code bits accepted in the current session.
    always_comb begin
        total_d   = total_q;
        total_sum = {1'b0, total_q} + 33'(sym_len);
        if (state_q == IDLE && TABLE_LOAD) begin
            total_d = '0;
        end else if (accept) begin
            total_d = total_sum[32] ? 32'hFFFF_FFFF : total_sum[31:0];
        end
    end

    // Bit counter register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            total_q <= '0;
        end else begin
            total_q <= total_d;
        end
    end

    assign TOTAL_BITS = total_q;
`endif

endmodule

// File: tb/tb_huffman_bit_packer.sv
// Self-checking bench for huffman_bit_packer (OUT_W = 8).
module tb_huffman_bit_packer;
    import huff_pkg::*;

    localparam logic [15:0] CT = 16'h7620;
    localparam logic [7:0]  LT = 8'b11_11_10_01;

    typedef struct {
        logic [1:0] sym;
        logic       last;
    } sym_t;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic [3:0] pad;
    } word_t;

    typedef struct {
        logic       valid;
        logic       xfer;
        logic [7:0] data;
        logic       last;
        logic [3:0] pad;
        logic       done;
        logic       sym_ready;
    } obs_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        TABLE_LOAD = 1'b0;
    logic [15:0] CODE_TABLE = '0;
    logic [7:0]  LEN_TABLE = '0;
    logic [1:0]  SYM = '0;
    logic        SYM_VALID = 1'b0;
    logic        SYM_LAST = 1'b0;
    logic        SYM_READY;
    logic [7:0]  OUT_DATA;
    logic        OUT_VALID;
    logic        OUT_LAST;
    logic [3:0]  OUT_PAD;
    logic        OUT_READY = 1'b0;
    logic        DONE;
    logic        ERR;
`ifdef HUFF_BIT_COUNT_EN
    logic [31:0] TOTAL_BITS;
`endif

    int checks = 0;
    int errors = 0;
    sym_t  sym_q[$];
    word_t exp_q[$];

    always #5 CLK = ~CLK;

    huffman_bit_packer #(.OUT_W(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .TABLE_LOAD (TABLE_LOAD),
        .CODE_TABLE (CODE_TABLE),
        .LEN_TABLE  (LEN_TABLE),
        .SYM        (SYM),
        .SYM_VALID  (SYM_VALID),
        .SYM_LAST   (SYM_LAST),
        .SYM_READY  (SYM_READY),
        .OUT_DATA   (OUT_DATA),
        .OUT_VALID  (OUT_VALID),
        .OUT_LAST   (OUT_LAST),
        .OUT_PAD    (OUT_PAD),
        .OUT_READY  (OUT_READY),
        .DONE       (DONE),
        .ERR        (ERR)
`ifdef HUFF_BIT_COUNT_EN
        ,
        .TOTAL_BITS (TOTAL_BITS)
`endif
    );

    task automatic load(input logic [15:0] ct, input logic [7:0] lt);
        CODE_TABLE = ct;
        LEN_TABLE  = lt;
        TABLE_LOAD = 1'b1;
        @(posedge CLK); #1;
        TABLE_LOAD = 1'b0;
    endtask

    task automatic push_sym(input logic [1:0] s, input logic l);
        sym_t e;
        e.sym = s; e.last = l;
        sym_q.push_back(e);
    endtask

    task automatic push_exp(input logic [7:0] d, input logic l, input logic [3:0] p);
        word_t w;
        w.data = d; w.last = l; w.pad = p;
        exp_q.push_back(w);
    endtask

    // One clock: present the head symbol, sample outputs at the falling edge.
    task automatic cycle(input logic rdy, output obs_t o);
        OUT_READY = rdy;
        if (sym_q.size() > 0) begin
            SYM_VALID = 1'b1;
            SYM       = sym_q[0].sym;
            SYM_LAST  = sym_q[0].last;
        end else begin
            SYM_VALID = 1'b0;
            SYM_LAST  = 1'b0;
        end
        @(negedge CLK);
        o.valid     = OUT_VALID;
        o.xfer      = OUT_VALID && rdy;
        o.data      = OUT_DATA;
        o.last      = OUT_LAST;
        o.pad       = OUT_PAD;
        o.done      = DONE;
        o.sym_ready = SYM_READY;
        if (SYM_VALID && SYM_READY) void'(sym_q.pop_front());
        @(posedge CLK); #1;
        SYM_VALID = 1'b0;
        SYM_LAST  = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        checks++;
        if ({SYM_READY, OUT_VALID, OUT_LAST, OUT_PAD, DONE, ERR, OUT_DATA} !== 17'd0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b v=%b l=%b pad=%0d done=%b err=%b data=%h expected all 0",
                     SYM_READY, OUT_VALID, OUT_LAST, OUT_PAD, DONE, ERR, OUT_DATA);
        end
`ifdef HUFF_BIT_COUNT_EN
        checks++;
        if (TOTAL_BITS !== 32'd0) begin
            errors++;
            $display("FAIL reset_total got %0d expected 0", TOTAL_BITS);
        end
`endif
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        checks++;
        if (SYM_READY !== 1'b0 || OUT_VALID !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset got rdy=%b valid=%b expected 0 0", SYM_READY, OUT_VALID);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_basic();
        obs_t o;
        word_t w;
        bit done_seen = 0;
        load(CT, LT);
        push_sym(SYM_A, 0); push_sym(SYM_B, 0); push_sym(SYM_C, 0); push_sym(SYM_D, 1);
        push_exp(8'h5B, 0, 4'd0);
        push_exp(8'h80, 1, 4'd7);
        for (int c = 0; c < 40 && !done_seen; c++) begin
            cycle(1'b1, o);
            if (o.xfer) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL basic_extra_word got %h expected none", o.data);
                end else begin
                    w = exp_q.pop_front();
                    if ({o.data, o.last, o.pad} !== {w.data, w.last, w.pad}) begin
                        errors++;
                        $display("FAIL basic_word got data=%h last=%b pad=%0d expected data=%h last=%b pad=%0d",
                                 o.data, o.last, o.pad, w.data, w.last, w.pad);
                    end
                end
            end
            if (o.done) done_seen = 1;
        end
        checks++;
        if (!done_seen || exp_q.size() != 0) begin
            errors++;
            $display("FAIL basic_done got done=%0b pending=%0d expected done=1 pending=0", done_seen, exp_q.size());
        end
`ifdef HUFF_BIT_COUNT_EN
        checks++;
        if (TOTAL_BITS !== 32'd9) begin
            errors++;
            $display("FAIL total_bits got %0d expected 9", TOTAL_BITS);
        end
`endif
        @(negedge CLK);
        checks++;
        if (DONE !== 1'b0 || SYM_READY !== 1'b0) begin
            errors++;
            $display("FAIL done_one_cycle got done=%b rdy=%b expected 0 0", DONE, SYM_READY);
        end
        @(posedge CLK); #1;
        exp_q.delete(); sym_q.delete();
    endtask

    task automatic test_eight_a();
        obs_t o;
        word_t w;
        bit done_seen = 0;
        load(CT, LT);
        for (int i = 0; i < 8; i++) push_sym(SYM_A, (i == 7));
        push_exp(8'h00, 1, 4'd0);
        for (int c = 0; c < 40 && !done_seen; c++) begin
            cycle(1'b1, o);
            if (o.xfer) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL eight_a_extra_word got %h expected none", o.data);
                end else begin
                    w = exp_q.pop_front();
                    if ({o.data, o.last, o.pad} !== {w.data, w.last, w.pad}) begin
                        errors++;
                        $display("FAIL eight_a_word got data=%h last=%b pad=%0d expected data=%h last=%b pad=%0d",
                                 o.data, o.last, o.pad, w.data, w.last, w.pad);
                    end
                end
            end
            if (o.done) done_seen = 1;
        end
        checks++;
        if (!done_seen || exp_q.size() != 0) begin
            errors++;
            $display("FAIL eight_a_done got done=%0b pending=%0d expected done=1 pending=0", done_seen, exp_q.size());
        end
        exp_q.delete(); sym_q.delete();
    endtask

    task automatic test_backpressure();
        obs_t o;
        word_t w;
        bit done_seen = 0;
        int held = 0;
        load(CT, LT);
        push_sym(SYM_D, 0); push_sym(SYM_D, 0); push_sym(SYM_D, 1);
        push_exp(8'hFF, 0, 4'd0);
        push_exp(8'h80, 1, 4'd7);
        for (int c = 0; c < 30 && held < 5; c++) begin
            cycle(1'b0, o);
            if (o.valid) begin
                held++;
                checks++;
                if (o.data !== 8'hFF || o.last !== 1'b0 || o.sym_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL hold_stable got data=%h last=%b rdy=%b expected data=ff last=0 rdy=0",
                             o.data, o.last, o.sym_ready);
                end
            end
        end
        checks++;
        if (held != 5) begin
            errors++;
            $display("FAIL hold_timeout got %0d held cycles expected 5", held);
        end
        for (int c = 0; c < 40 && !done_seen; c++) begin
            cycle(1'b1, o);
            if (o.xfer) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL bp_extra_word got %h expected none", o.data);
                end else begin
                    w = exp_q.pop_front();
                    if ({o.data, o.last, o.pad} !== {w.data, w.last, w.pad}) begin
                        errors++;
                        $display("FAIL bp_word got data=%h last=%b pad=%0d expected data=%h last=%b pad=%0d",
                                 o.data, o.last, o.pad, w.data, w.last, w.pad);
                    end
                end
            end
            if (o.done) done_seen = 1;
        end
        checks++;
        if (!done_seen || exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_done got done=%0b pending=%0d expected done=1 pending=0", done_seen, exp_q.size());
        end
        exp_q.delete(); sym_q.delete();
    endtask

    task automatic test_err();
        obs_t o;
        word_t w;
        bit done_seen = 0;
        load(CT, 8'b11_11_10_00);
        push_sym(SYM_A, 0); push_sym(SYM_B, 1);
        push_exp(8'h80, 1, 4'd6);
        for (int c = 0; c < 40 && !done_seen; c++) begin
            cycle(1'b1, o);
            if (o.xfer) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL err_extra_word got %h expected none", o.data);
                end else begin
                    w = exp_q.pop_front();
                    if ({o.data, o.last, o.pad} !== {w.data, w.last, w.pad}) begin
                        errors++;
                        $display("FAIL err_word got data=%h last=%b pad=%0d expected data=%h last=%b pad=%0d",
                                 o.data, o.last, o.pad, w.data, w.last, w.pad);
                    end
                end
            end
            if (o.done) done_seen = 1;
        end
        checks++;
        if (!done_seen || exp_q.size() != 0) begin
            errors++;
            $display("FAIL err_done got done=%0b pending=%0d expected done=1 pending=0", done_seen, exp_q.size());
        end
        @(negedge CLK);
        checks++;
        if (ERR !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky got %b expected 1", ERR);
        end
        @(posedge CLK); #1;
        exp_q.delete(); sym_q.delete();
    endtask

    task automatic test_zero_bit();
        obs_t o;
        bit done_seen = 0;
        int words = 0;
        load(CT, 8'b11_11_10_00);
        @(negedge CLK);
        checks++;
        if (ERR !== 1'b0) begin
            errors++;
            $display("FAIL err_cleared_by_load got %b expected 0", ERR);
        end
        @(posedge CLK); #1;
        push_sym(SYM_A, 1);
        for (int c = 0; c < 20 && !done_seen; c++) begin
            cycle(1'b1, o);
            if (o.xfer) words++;
            if (o.done) done_seen = 1;
        end
        checks++;
        if (!done_seen || words != 0 || ERR !== 1'b1) begin
            errors++;
            $display("FAIL zero_bit got done=%0b words=%0d err=%b expected done=1 words=0 err=1",
                     done_seen, words, ERR);
        end
        exp_q.delete(); sym_q.delete();
    endtask

    task automatic test_table_load_ignored();
        obs_t o;
        word_t w;
        bit done_seen = 0;
        load(CT, LT);
        push_sym(SYM_A, 0); push_sym(SYM_B, 0); push_sym(SYM_C, 0); push_sym(SYM_D, 1);
        push_exp(8'h5B, 0, 4'd0);
        push_exp(8'h80, 1, 4'd7);
        for (int c = 0; c < 40 && !done_seen; c++) begin
            if (c == 1) begin
                TABLE_LOAD = 1'b1;
                CODE_TABLE = 16'hFFFF;
                LEN_TABLE  = 8'hFF;
            end else begin
                TABLE_LOAD = 1'b0;
            end
            cycle(1'b1, o);
            if (o.xfer) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL reload_extra_word got %h expected none", o.data);
                end else begin
                    w = exp_q.pop_front();
                    if ({o.data, o.last, o.pad} !== {w.data, w.last, w.pad}) begin
                        errors++;
                        $display("FAIL reload_word got data=%h last=%b pad=%0d expected data=%h last=%b pad=%0d",
                                 o.data, o.last, o.pad, w.data, w.last, w.pad);
                    end
                end
            end
            if (o.done) done_seen = 1;
        end
        TABLE_LOAD = 1'b0;
        checks++;
        if (!done_seen || exp_q.size() != 0) begin
            errors++;
            $display("FAIL reload_done got done=%0b pending=%0d expected done=1 pending=0", done_seen, exp_q.size());
        end
        exp_q.delete(); sym_q.delete();
    endtask

    task automatic test_rst_mid();
        obs_t o;
        load(CT, LT);
        for (int i = 0; i < 4; i++) push_sym(SYM_D, 0);
        for (int c = 0; c < 4; c++) cycle(1'b0, o);
        checks++;
        if (OUT_VALID !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pending got valid=%b expected 1", OUT_VALID);
        end
        RST = 1'b1;
        #2;
        checks++;
        if ({SYM_READY, OUT_VALID, OUT_LAST, OUT_PAD, DONE, ERR, OUT_DATA} !== 17'd0) begin
            errors++;
            $display("FAIL rst_mid_outputs got rdy=%b v=%b l=%b pad=%0d done=%b err=%b data=%h expected all 0",
                     SYM_READY, OUT_VALID, OUT_LAST, OUT_PAD, DONE, ERR, OUT_DATA);
        end
        sym_q.delete(); exp_q.delete();
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        checks++;
        if (SYM_READY !== 1'b0 || OUT_VALID !== 1'b0 || OUT_DATA !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid_idle got rdy=%b valid=%b data=%h expected 0 0 00", SYM_READY, OUT_VALID, OUT_DATA);
        end
        @(posedge CLK); #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_eight_a();
        test_backpressure();
        test_err();
        test_zero_bit();
        test_table_load_ignored();
        test_rst_mid();
        test_basic();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
